// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared types and constants for the core pipeline stage registers.
//
// Contents:
//   * per-stage payload structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t)
//   * their packed widths (IF_ID_W .. MEM_WB_W), used as DATA_W of pipe_stage_skid
//   * field-level invalid constants and the per-stage INV_VAL vectors that a
//     stage drives on its m_data while it holds nothing
//
// The stage register itself treats the payload as an opaque vector, so each
// INV_VAL below is laid out in the same field order as its struct.

package pipe_pkg;

  // Field-level "nothing here" values. DATA_INVALID doubles as the bubble
  // instruction (addi x0, x0, 0), so an empty slot decodes as a harmless NOP.
  localparam logic [31:0] ADDR_INVALID     = 32'hDEAD_DEAD;
  localparam logic [31:0] DATA_INVALID     = 32'h0000_0013;
  localparam logic [4:0]  REG_ADDR_INVALID = 5'd0;
  localparam logic        EN_INVALID       = 1'b0;

  // IF/ID: fetched instruction and its address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  // ID/EX: decoded operands plus destination register.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd_addr;
    logic        rd_en;
  } id_ex_t;

  // EX/MEM: ALU result and store data.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu_res;
    logic [31:0] st_data;
    logic [4:0]  rd_addr;
    logic        rd_en;
  } ex_mem_t;

  // MEM/WB: register write-back request.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rw_data;
    logic [4:0]  rw_addr;
    logic        rw_en;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  // Invalid payloads, concatenated in struct field order (MSB first).
  localparam logic [IF_ID_W-1:0] IF_ID_INV_VAL = {
    ADDR_INVALID, DATA_INVALID
  };

  localparam logic [ID_EX_W-1:0] ID_EX_INV_VAL = {
    ADDR_INVALID, DATA_INVALID, DATA_INVALID, DATA_INVALID, DATA_INVALID,
    REG_ADDR_INVALID, EN_INVALID
  };

  localparam logic [EX_MEM_W-1:0] EX_MEM_INV_VAL = {
    ADDR_INVALID, DATA_INVALID, DATA_INVALID, DATA_INVALID,
    REG_ADDR_INVALID, EN_INVALID
  };

  localparam logic [MEM_WB_W-1:0] MEM_WB_INV_VAL = {
    ADDR_INVALID, DATA_INVALID, DATA_INVALID,
    REG_ADDR_INVALID, EN_INVALID
  };

endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt -- 32-bit saturating event counter for stage statistics.
//
// Built only when PIPE_STAGE_PERF_EN is defined; the default build carries
// no performance logic at all.
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high clear
//   inc  in   count this cycle
//   cnt  out  current count, sticks at 32'hFFFF_FFFF

`ifdef PIPE_STAGE_PERF_EN

module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] r_cnt;
  logic        w_sat;

  assign w_sat = &r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && !w_sat) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign cnt = r_cnt;

endmodule

`endif

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid -- pipeline stage register with valid/ready handshake and a
// two-entry skid buffer (main slot + skid slot).
//
// s_ready depends only on registered state plus the local stall/flush/rst
// controls, never on m_ready, so ready paths do not chain through the
// pipeline, yet a stream still moves at one transfer per cycle.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset, beats flush and stall
//   s_valid  in   upstream payload valid
//   s_ready  out  stage accepts this cycle
//   s_data   in   upstream payload [DATA_W]
//   m_valid  out  downstream payload valid
//   m_ready  in   downstream accepts
//   m_data   out  downstream payload [DATA_W], INV_VAL when empty
//   stall    in   freeze: no accept, no emit, state held
//   flush    in   drop every held entry on the next edge (beats stall)
//   occ      out  entries held, 0..2
// Optional (macro PIPE_STAGE_PERF_EN):
//   stall_cnt   out  cycles with stall=1
//   bubble_cnt  out  cycles with stall=0 and the main slot empty
//   bp_cnt      out  cycles with m_valid=1 and m_ready=0
//
// Parameters:
//   DATA_W   payload width, defaults to the MEM/WB payload
//   INV_VAL  payload shown on m_data while the stage holds nothing

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = MEM_WB_W,
  parameter logic [DATA_W-1:0] INV_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occ
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       bp_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              r_main_v;
  logic [DATA_W-1:0] r_main_d;
  logic              r_sk_v;
  logic [DATA_W-1:0] r_sk_d;
  logic [1:0]        r_occ;

  logic              w_main_v_next;
  logic [DATA_W-1:0] w_main_d_next;
  logic              w_sk_v_next;
  logic [DATA_W-1:0] w_sk_d_next;
  logic [1:0]        w_occ_next;

  logic              w_s_ready;
  logic              w_m_valid;
  logic              w_in_fire;
  logic              w_out_fire;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // A full skid slot is the only occupancy that blocks input: with just the
  // main slot held, an incoming beat can always park in the skid slot.
  // rst is folded in so nothing is accepted while the stage is being cleared.
  assign w_s_ready  = !r_sk_v && !stall && !flush && !rst;
  assign w_m_valid  = r_main_v && !stall && !rst;
  assign w_in_fire  = s_valid && w_s_ready;
  assign w_out_fire = w_m_valid && m_ready;

  // ---------------------------------------------------------------------------
  // Next state: drain first, then fill, so a beat arriving while main leaves
  // lands in main and occupancy stays put.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_main_v_next = r_main_v;
    w_main_d_next = r_main_d;
    w_sk_v_next   = r_sk_v;
    w_sk_d_next   = r_sk_d;

    if (flush) begin
      w_main_v_next = 1'b0;
      w_main_d_next = INV_VAL;
      w_sk_v_next   = 1'b0;
      w_sk_d_next   = INV_VAL;
    end else if (!stall) begin
      if (w_out_fire) begin
        if (r_sk_v) begin
          // Oldest waiting entry moves up; skid slot goes back to invalid.
          w_main_v_next = 1'b1;
          w_main_d_next = r_sk_d;
          w_sk_v_next   = 1'b0;
          w_sk_d_next   = INV_VAL;
        end else begin
          w_main_v_next = 1'b0;
          w_main_d_next = INV_VAL;
        end
      end

      if (w_in_fire) begin
        if (!w_main_v_next) begin
          w_main_v_next = 1'b1;
          w_main_d_next = s_data;
        end else begin
          // Main is held and not leaving: absorb the beat in the skid slot.
          w_sk_v_next = 1'b1;
          w_sk_d_next = s_data;
        end
      end
    end

    w_occ_next = {1'b0, w_main_v_next} + {1'b0, w_sk_v_next};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_main_d <= INV_VAL;
      r_sk_v   <= 1'b0;
      r_sk_d   <= INV_VAL;
      r_occ    <= 2'd0;
    end else begin
      r_main_v <= w_main_v_next;
      r_main_d <= w_main_d_next;
      r_sk_v   <= w_sk_v_next;
      r_sk_d   <= w_sk_d_next;
      r_occ    <= w_occ_next;
    end
  end

  assign s_ready = w_s_ready;
  assign m_valid = w_m_valid;
  assign m_data  = r_main_d;
  assign occ     = r_occ;

  // ---------------------------------------------------------------------------
  // Optional statistics; they observe the handshake but never feed back.
  // ---------------------------------------------------------------------------
`ifdef PIPE_STAGE_PERF_EN
  logic w_stall_inc;
  logic w_bubble_inc;
  logic w_bp_inc;

  assign w_stall_inc  = stall;
  assign w_bubble_inc = !stall && !r_main_v;
  assign w_bp_inc     = w_m_valid && !m_ready;

  pipe_perf_cnt u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall_inc),
    .cnt (stall_cnt)
  );

  pipe_perf_cnt u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_bubble_inc),
    .cnt (bubble_cnt)
  );

  pipe_perf_cnt u_bp_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_bp_inc),
    .cnt (bp_cnt)
  );
`endif

endmodule
